alu_exec_unit: RTL and testbench

//  Execute-stage ALU for the RV32 core; consumes ALUOpT ops + operands from decode, returns result + rd to writeback.

---
 rtl/rv32_pkg.sv | 76 +++++++
 rtl/alu_exec_unit_if.sv | 29 ++
 rtl/alu_exec_unit_shift_iter.sv | 82 ++++++++
 rtl/alu_exec_unit.sv | 111 +++++++++++
 tb/tb_alu_exec_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: ALU opcode encoding, FSM states and
// single-cycle ALU helpers used by alu_exec_unit.
package rv32_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int SHAMT_WIDTH    = $clog2(DATA_WIDTH);

  typedef enum logic [7:0] {
    isADD   = 8'h01,
    isSUB   = 8'h02,
    isXOR   = 8'h03,
    isOR    = 8'h04,
    isAND   = 8'h05,
    isSLL   = 8'h06,
    isSRL   = 8'h07,
    isSRA   = 8'h08,
    isSLT   = 8'h09,
    isSLTU  = 8'h0A,
    isPASSB = 8'h0B,
    invalid = 8'hFF
  } ALUOpT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h0B);
  endfunction

  function automatic logic is_shift_op(input logic [7:0] op);
    return (op == isSLL) || (op == isSRL) || (op == isSRA);
  endfunction

  function automatic shift_mode_e to_shift_mode(input logic [7:0] op);
    shift_mode_e m;
    case (op)
      isSRL:   m = SH_SRL;
      isSRA:   m = SH_SRA;
      default: m = SH_SLL;
    endcase
    return m;
  endfunction

  // Shift opcodes only reach this path with a zero shift amount, so they pass A through.
  function automatic logic [DATA_WIDTH-1:0] alu_single(input logic [7:0] op,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      isADD:   r = a + b;
      isSUB:   r = a - b;
      isXOR:   r = a ^ b;
      isOR:    r = a | b;
      isAND:   r = a & b;
      isSLL,
      isSRL,
      isSRA:   r = a;
      isSLT:   r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      isSLTU:  r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      isPASSB: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Decode-to-ALU request channel and ALU-to-writeback result channel,
// plus the mispredict flush that kills the in-flight op.
interface alu_exec_unit_if;
  import rv32_pkg::*;

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [7:0]                in_op;
  logic [DATA_WIDTH-1:0]     in_a;
  logic [DATA_WIDTH-1:0]     in_b;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_result;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic                      out_illegal;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );

endinterface

// File: rtl/alu_exec_unit_shift_iter.sv
// Iterative shifter: moves the value by up to STEP bits per cycle until the
// requested amount is consumed. done_o flags the cycle of the final step.
module shift_iter
  import rv32_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int STEP  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     kill_i,
  input  logic                     start_i,
  input  shift_mode_e              mode_i,
  input  logic [WIDTH-1:0]         value_i,
  input  logic [$clog2(WIDTH)-1:0] amount_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [WIDTH-1:0]         result_o
);

  // One extra bit so a STEP equal to WIDTH is still representable.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  logic [WIDTH-1:0] value_q, value_d, shifted_s;
  logic [CW-1:0]    remain_q, remain_d, step_s;
  shift_mode_e      mode_q, mode_d;
  logic             busy_q, busy_d;

  // Per-cycle step: the full STEP, or whatever remains if less.
  always_comb begin
    step_s = (remain_q > STEP_C) ? STEP_C : remain_q;
    case (mode_q)
      SH_SLL:  shifted_s = value_q << step_s;
      SH_SRL:  shifted_s = value_q >> step_s;
      SH_SRA:  shifted_s = WIDTH'($signed(value_q) >>> step_s);
      default: shifted_s = value_q;
    endcase
  end

  // Load, step and kill sequencing.
  always_comb begin
    value_d  = value_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    if (kill_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      value_d  = value_i;
      remain_d = CW'(amount_i);
      mode_d   = mode_i;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      value_d  = shifted_s;
      remain_d = remain_q - step_s;
      busy_d   = !done_o;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_q  <= '0;
      remain_q <= '0;
      mode_q   <= SH_SLL;
      busy_q   <= 1'b0;
    end else begin
      value_q  <= value_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = busy_q && (remain_q <= STEP_C);
  assign result_o = shifted_s;

endmodule

// File: rtl/alu_exec_unit.sv
// RV32 execute-stage ALU: single-cycle arithmetic/logic ops, iterative shifts,
// valid/ready on both sides with zero-bubble back-to-back issue from DONE.
module alu_exec_unit
  import rv32_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic            clock,
  input  logic            reset,
  alu_exec_unit_if.slave  bus
);

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     result_q, result_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      illegal_q, illegal_d;

  logic                      in_ready_s;
  logic                      accept_s;
  logic                      shift_start_s;
  logic                      sh_busy_s;
  logic                      sh_done_s;
  logic [DATA_WIDTH-1:0]     sh_result_s;
  logic [SHAMT_WIDTH-1:0]    shamt_s;

  assign shamt_s    = bus.in_b[SHAMT_WIDTH-1:0];
  assign in_ready_s = !bus.flush &&
                      ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
  assign accept_s   = bus.in_valid && in_ready_s;

  shift_iter #(
    .WIDTH (DATA_WIDTH),
    .STEP  (SHIFT_STEP)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .kill_i   (bus.flush),
    .start_i  (shift_start_s),
    .mode_i   (to_shift_mode(bus.in_op)),
    .value_i  (bus.in_a),
    .amount_i (shamt_s),
    .busy_o   (sh_busy_s),
    .done_o   (sh_done_s),
    .result_o (sh_result_s)
  );

  // Next-state and result capture; flush overrides everything.
  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    rd_d          = rd_q;
    illegal_d     = illegal_q;
    shift_start_s = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            rd_d      = bus.in_rd;
            illegal_d = !is_legal_op(bus.in_op);
            if (is_shift_op(bus.in_op) && (shamt_s != '0)) begin
              state_d       = ST_SHIFT;
              shift_start_s = 1'b1;
            end else begin
              state_d  = ST_DONE;
              result_d = alu_single(bus.in_op, bus.in_a, bus.in_b);
            end
          end else if ((state_q == ST_DONE) && bus.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        ST_SHIFT: begin
          if (sh_done_s) begin
            state_d  = ST_DONE;
            result_d = sh_result_s;
          end else if (!sh_busy_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_result  = result_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, handshake
// corner sequences, and random ops against a plain-arithmetic reference.
module tb_alu_exec_unit;
  import rv32_pkg::*;

  localparam int STEP = 4;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  alu_exec_unit_if bus();

  alu_exec_unit #(.SHIFT_STEP(STEP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: result from the op definitions, latency from ceil(shamt/STEP).
  function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (op)
      8'h01: res = a + b;
      8'h02: res = a - b;
      8'h03: res = a ^ b;
      8'h04: res = a | b;
      8'h05: res = a & b;
      8'h06: res = a << sh;
      8'h07: res = a >> sh;
      8'h08: res = 32'($signed(a) >>> sh);
      8'h09: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      8'h0A: res = (a < b) ? 32'd1 : 32'd0;
      8'h0B: res = b;
      default: begin
        res = 32'd0;
        ill = 1'b1;
      end
    endcase
    if (op >= 8'h06 && op <= 8'h08) lat = 1 + (sh + STEP - 1) / STEP;
  endfunction

  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rd     = rd;
    bus.out_ready = 1'b0;
    #1;
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 64) begin
      tick();
      n++;
    end
    check({name, " latency"}, n, exp_lat);
    check({name, " result"}, bus.out_result, exp_res);
    check({name, " rd"}, 32'(bus.out_rd), 32'(rd));
    check({name, " illegal"}, 32'(bus.out_illegal), 32'(exp_ill));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, " idle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] eres;
    logic        eill;
    int          elat;
    logic [7:0]  rop;
    int          r;
    bit          seen;

    vecs[0]  = '{8'h01, 32'hFFFF_FFFF, 32'd1,         5'd5,  32'h0000_0000, 1'b0, 1};
    vecs[1]  = '{8'h08, 32'h8000_0000, 32'd31,        5'd3,  32'hFFFF_FFFF, 1'b0, 9};
    vecs[2]  = '{8'h06, 32'h1234_5678, 32'd0,         5'd7,  32'h1234_5678, 1'b0, 1};
    vecs[3]  = '{8'h09, 32'hFFFF_FFFF, 32'd1,         5'd1,  32'h0000_0001, 1'b0, 1};
    vecs[4]  = '{8'h0A, 32'hFFFF_FFFF, 32'd1,         5'd2,  32'h0000_0000, 1'b0, 1};
    vecs[5]  = '{8'h0B, 32'h0000_0000, 32'h0000_1234, 5'd8,  32'h0000_1234, 1'b0, 1};
    vecs[6]  = '{8'hFF, 32'h0000_DEAD, 32'h0000_BEEF, 5'd9,  32'h0000_0000, 1'b1, 1};
    vecs[7]  = '{8'h00, 32'h1111_1111, 32'h2222_2222, 5'd10, 32'h0000_0000, 1'b1, 1};
    vecs[8]  = '{8'h02, 32'h0000_0000, 32'd1,         5'd11, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[9]  = '{8'h07, 32'h8000_0000, 32'd4,         5'd12, 32'h0800_0000, 1'b0, 2};
    vecs[10] = '{8'h06, 32'h0000_0001, 32'd5,         5'd13, 32'h0000_0020, 1'b0, 3};
    vecs[11] = '{8'h08, 32'hF000_0000, 32'h0000_0124, 5'd14, 32'hFF00_0000, 1'b0, 2};
    vecs[12] = '{8'h03, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd15, 32'h5A5A_A5A5, 1'b0, 1};
    vecs[13] = '{8'h05, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd16, 32'hF000_F000, 1'b0, 1};
    vecs[14] = '{8'h0C, 32'h0000_0001, 32'h0000_0001, 5'd17, 32'h0000_0000, 1'b1, 1};

    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 8'h00;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b0;
    #12;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst result", bus.out_result, 32'd0);
    check("rst rd", 32'(bus.out_rd), 32'd0);
    check("rst illegal", 32'(bus.out_illegal), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].res, vecs[i].ill, vecs[i].lat);
    end

    // Backpressure in DONE, then three back-to-back ADDs.
    bus.in_valid = 1'b1; bus.in_op = 8'h01; bus.in_a = 32'd10; bus.in_b = 32'd20; bus.in_rd = 5'd2;
    bus.out_ready = 1'b0;
    tick();
    check("stall first valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_rd = 5'd30;
      #1;
      check($sformatf("stall%0d in_ready", i), 32'(bus.in_ready), 32'd0);
      tick();
      check($sformatf("stall%0d valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("stall%0d result", i), bus.out_result, 32'd30);
      check($sformatf("stall%0d rd", i), 32'(bus.out_rd), 32'd2);
    end
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; bus.in_op = 8'h01; bus.in_a = 32'(k + 1); bus.in_b = 32'd100;
      bus.in_rd = 5'(k + 20); bus.out_ready = 1'b1;
      #1;
      check($sformatf("b2b%0d in_ready", k), 32'(bus.in_ready), 32'd1);
      tick();
      check($sformatf("b2b%0d valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("b2b%0d result", k), bus.out_result, 32'(k + 101));
      check($sformatf("b2b%0d rd", k), 32'(bus.out_rd), 32'(k + 20));
    end
    bus.in_valid = 1'b0;
    tick();
    check("b2b drain", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Flush an SRL mid-shift; same-cycle request must be refused.
    bus.in_valid = 1'b1; bus.in_op = 8'h07; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'd20; bus.in_rd = 5'd4;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_op = 8'h01; bus.in_a = 32'd5; bus.in_b = 32'd6;
    #1;
    check("flush in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    run_op("post_flush", 8'h01, 32'd5, 32'd6, 5'd6, 32'd11, 1'b0, 1);

    // Async reset in the middle of an SRA.
    bus.in_valid = 1'b1; bus.in_op = 8'h08; bus.in_a = 32'h8000_0000; bus.in_b = 32'd31; bus.in_rd = 5'd12;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst result", bus.out_result, 32'd0);
    check("midrst rd", 32'(bus.out_rd), 32'd0);
    #2;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst no result", 32'(seen), 32'd0);
    run_op("post_rst", 8'h01, 32'd7, 32'd8, 5'd1, 32'd15, 1'b0, 1);

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 12));
      if (r == 12) rop = 8'(12 + $urandom_range(0, 243));
      else         rop = 8'(r);
      begin
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 3) == 0) rb = ra;
        model(rop, ra, rb, eres, eill, elat);
        run_op($sformatf("rnd%0d op%02h", i, rop), rop, ra, rb, 5'($urandom), eres, eill, elat);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
